// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall, flush, per-stage
// kill and bubble insertion that forces control to a safe value.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 64,
  parameter logic [CTRL_W-1:0] CTRL_SAFE = '0,
  parameter int unsigned DEPTH = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [DEPTH-1:0]  kill,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  vld_count,
  output logic [15:0]       stall_cnt
);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [CTRL_W-1:0] c_q [DEPTH];
  logic [CTRL_W-1:0] c_d [DEPTH];
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [15:0]       scnt_q, scnt_d;

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      c_d[i] = c_q[i];
      d_d[i] = d_q[i];
    end
    if (flush) begin
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) c_d[i] = CTRL_SAFE;
    end else if (stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) begin
          v_d[i] = 1'b0;
          c_d[i] = CTRL_SAFE;
        end
      end
    end else begin
      v_d[0] = in_valid;
      c_d[0] = in_valid ? in_ctrl : CTRL_SAFE;
      d_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i] = v_q[i-1] & ~kill[i-1];
        c_d[i] = v_d[i] ? c_q[i-1] : CTRL_SAFE;
        d_d[i] = d_q[i-1];
      end
    end
  end

  always_comb begin
    scnt_d = 16'd0;
    if (stall && !flush)
      scnt_d = (scnt_q == 16'hFFFF) ? scnt_q : scnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      scnt_q <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        c_q[i] <= CTRL_SAFE;
        d_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      scnt_q <= scnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        c_q[i] <= c_d[i];
        d_q[i] <= d_d[i];
      end
    end
  end

  always_comb begin
    vld_count = '0;
    for (int i = 0; i < DEPTH; i++)
      vld_count = vld_count + CNT_W'(v_q[i]);
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_ctrl  = c_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign stall_cnt = scnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg (DEPTH=3) against a slot-queue
// reference model of in-flight items.
module tb_pipe_stage_reg;

  localparam int D = 3;
  localparam logic [15:0] SAFE = 16'h5A0F;

  typedef struct {
    logic        v;
    logic [15:0] c;
    logic [31:0] d;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;
  logic        stall, flush;
  logic [D-1:0] kill;
  logic        out_valid;
  logic [15:0] out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  vld_count;
  logic [15:0] stall_cnt;

  pipe_stage_reg #(
    .CTRL_W(16), .DATA_W(32), .CTRL_SAFE(SAFE), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .stall(stall), .flush(flush), .kill(kill),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data),
    .vld_count(vld_count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // pipe[0] is the youngest item, pipe[D-1] is the one presented at out_*
  slot_t pipe[$];
  int    m_scnt;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    slot_t s;
    s.v = 1'b0; s.c = SAFE; s.d = '0;
    pipe.delete();
    for (int i = 0; i < D; i++) pipe.push_back(s);
    m_scnt = 0;
  endtask

  task automatic model_step(input logic iv, input logic [15:0] ic,
                            input logic [31:0] id, input logic st,
                            input logic fl, input logic [D-1:0] kl);
    slot_t s;
    if (fl) begin
      foreach (pipe[i]) begin pipe[i].v = 1'b0; pipe[i].c = SAFE; end
    end else if (st) begin
      foreach (pipe[i])
        if (kl[i]) begin pipe[i].v = 1'b0; pipe[i].c = SAFE; end
    end else begin
      foreach (pipe[i])
        if (kl[i]) begin pipe[i].v = 1'b0; pipe[i].c = SAFE; end
      void'(pipe.pop_back());
      s.v = iv; s.c = iv ? ic : SAFE; s.d = id;
      pipe.push_front(s);
    end
    if (st && !fl) m_scnt = (m_scnt + 1 > 65535) ? 65535 : m_scnt + 1;
    else m_scnt = 0;
  endtask

  function automatic int m_count();
    int n = 0;
    foreach (pipe[i]) n += int'(pipe[i].v);
    return n;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(pipe[D-1].v));
    chk({tag, ".ctrl"},  64'(out_ctrl),  64'(pipe[D-1].c));
    chk({tag, ".data"},  64'(out_data),  64'(pipe[D-1].d));
    chk({tag, ".vcnt"},  64'(vld_count), 64'(m_count()));
    chk({tag, ".scnt"},  64'(stall_cnt), 64'(m_scnt));
  endtask

  task automatic cyc(input string tag, input logic iv, input logic [15:0] ic,
                     input logic [31:0] id, input logic st, input logic fl,
                     input logic [D-1:0] kl);
    in_valid = iv; in_ctrl = ic; in_data = id;
    stall = st; flush = fl; kill = kl;
    @(posedge clk);
    model_step(iv, ic, id, st, fl, kl);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    stall = 1'b0; flush = 1'b0; kill = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset.ctrl_safe", 64'(out_ctrl), 64'(SAFE));
    rst = 1'b0;

    // stream 1..4: item 1 appears after three edges
    for (int i = 1; i <= 4; i++) begin
      cyc("stream", 1'b1, 16'(i * 16'h0101), 32'(i), 1'b0, 1'b0, '0);
      if (i == 3) chk("stream.first", 64'(out_data), 64'd1);
    end
    chk("stream.second", 64'(out_data), 64'd2);
    chk("stream.full", 64'(vld_count), 64'd3);

    // bubble with all-ones ctrl must exit as SAFE
    cyc("bubble", 1'b0, 16'hFFFF, 32'hB0B0, 1'b0, 1'b0, '0);
    cyc("bubble", 1'b1, 16'h1111, 32'h55, 1'b0, 1'b0, '0);
    cyc("bubble", 1'b1, 16'h2222, 32'h66, 1'b0, 1'b0, '0);
    chk("bubble.valid", 64'(out_valid), 64'd0);
    chk("bubble.ctrl", 64'(out_ctrl), 64'(SAFE));

    // stall five cycles, outputs frozen
    for (int i = 0; i < 5; i++)
      cyc("stall", 1'b1, 16'hDEAD, 32'hDEAD, 1'b1, 1'b0, '0);
    chk("stall.cnt5", 64'(stall_cnt), 64'd5);
    chk("stall.frozen", 64'(out_data), 64'hB0B0);
    for (int i = 0; i < 3; i++)
      cyc("release", 1'b1, 16'(i + 7), 32'(i + 100), 1'b0, 1'b0, '0);

    // kill middle stage under stall
    chk("kill.pre", 64'(vld_count), 64'd3);
    cyc("kill", 1'b1, 16'h0, 32'h0, 1'b1, 1'b0, 3'b010);
    chk("kill.post", 64'(vld_count), 64'd2);
    for (int i = 0; i < 3; i++)
      cyc("kill_rel", 1'b1, 16'(i + 9), 32'(i + 200), 1'b0, 1'b0, '0);

    // stall + flush together
    cyc("sf_pre", 1'b1, 16'h3, 32'h3, 1'b1, 1'b0, '0);
    cyc("stall_flush", 1'b1, 16'h4, 32'h4, 1'b1, 1'b1, '0);
    chk("sf.vcnt", 64'(vld_count), 64'd0);
    chk("sf.scnt", 64'(stall_cnt), 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [D-1:0] kl;
      kl = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
      cyc("rand", 1'($urandom_range(0, 4) != 0), 16'($urandom), $urandom,
          $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, kl);
    end

    // async reset mid-stream with all stages valid
    for (int i = 0; i < D; i++)
      cyc("prefill", 1'b1, 16'(i + 1), 32'(i + 300), 1'b0, 1'b0, '0);
    chk("prefill.full", 64'(vld_count), 64'd3);
    cyc("prestall", 1'b1, 16'h1, 32'h1, 1'b1, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // long stall saturates the counter
    cyc("fill", 1'b1, 16'hABCD, 32'h1234, 1'b0, 1'b0, '0);
    stall = 1'b1; flush = 1'b0; kill = '0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      model_step(1'b1, 16'h0, 32'h0, 1'b1, 1'b0, '0);
    end
    @(negedge clk);
    check_all("sat");
    chk("sat.max", 64'(stall_cnt), 64'hFFFF);
    cyc("sat_rel", 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the CPU datapath, successor to the fixed-field ID→EX latch. Carries a packed control word and a packed data word through DEPTH back-to-back register stages, each with its own valid bit. Adds global stall (hold), global flush, per-stage kill (selective squash), and automatic bubble insertion that forces control fields to a safe value. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, replacing hand-written latches.

## Interface
- CTRL_W, 16, width of control word (write enables, selects, halt, etc.); 1..64
- DATA_W, 64, width of data word (immediates, PC data, dst reg, etc.); 1..256
- CTRL_SAFE, {CTRL_W{1'b0}}, control value loaded on reset, flush, kill or bubble
- DEPTH, 1, number of register stages; 1..4
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ctrl  in  CTRL_W  upstream control word
- in_data  in  DATA_W  upstream data word
- stall  in  1  hold all stages this cycle
- flush  in  1  squash all stages this cycle
- kill  in  DEPTH  per-stage squash; bit i targets stage i (0 = input side)
- out_valid  out  1  valid of stage DEPTH-1
- out_ctrl  out  CTRL_W  control of stage DEPTH-1
- out_data  out  DATA_W  data of stage DEPTH-1
- vld_count  out  clog2(DEPTH+1)  number of valid stages
- stall_cnt  out  16  consecutive stalled cycles, saturating

## Operation
- Per stage i: registers v[i], c[i], d[i]. Outputs are registered copies of stage DEPTH-1, no combinational path from inputs.
- Reset (async, rst=1): all v=0, all c=CTRL_SAFE, all d=0, stall_cnt=0; vld_count=0.
- Priority per edge: flush > stall > advance.
- flush=1: all v←0, all c←CTRL_SAFE; d held. Overrides stall and kill.
- stall=1 (no flush): every d held; c[i],v[i] held unless kill[i]=1, then v[i]←0, c[i]←CTRL_SAFE. Input is not captured (upstream must hold it).
- Advance (stall=0, flush=0):
  - stage 0: v←in_valid; c←in_valid ? in_ctrl : CTRL_SAFE; d←in_data (always captured).
  - stage i>0: v[i]←v[i-1] & ~kill[i-1]; c[i]←(that result) ? c[i-1] : CTRL_SAFE; d[i]←d[i-1].
  - kill[DEPTH-1] during advance drops the outgoing instruction only (it has already been presented on out_* this cycle; bit meaningful only under stall).
- Invariant: v[i]=0 ⇒ c[i]=CTRL_SAFE. Downstream may use out_ctrl alone without gating by out_valid.
- vld_count = popcount(v), combinational from registered v.
- stall_cnt: ←0 when stall=0 or flush=1; else ←stall_cnt+1, saturating at 16'hFFFF.

## Timing
- Latency DEPTH cycles input→output when no stall.
- Throughput one item/cycle; no bubbles inserted except by in_valid=0, flush or kill.
- stall N cycles adds exactly N cycles to every in-flight item; no item lost or duplicated.
- flush effective on the edge where sampled; out_valid=0 from the next cycle; item presented at in_* in the flush cycle is discarded.
- Simultaneous stall+flush: flush result; stall_cnt←0.
- Simultaneous kill[i] and advance: killed item becomes a bubble in stage i+1 next cycle.
- rst mid-stream: outputs go to reset values immediately (asynchronously), not at next edge.
- DEPTH=1: single latch; kill[0] meaningful only under stall.

## Test plan
- Reset: drive rst=1 mid-stream with v all 1 -> out_valid=0, out_ctrl=CTRL_SAFE, out_data=0, vld_count=0, stall_cnt=0 before next clk edge.
- Stream, DEPTH=3: in_valid=1, in_data=1,2,3,4 on cycles 0..3 -> out_data=1 on cycle 3, then 2,3,4; vld_count reaches 3.
- Bubble: in_valid=0 with in_ctrl=16'hFFFF -> that slot exits with out_valid=0, out_ctrl=16'h0000.
- Stall: DEPTH=2, stall=1 for 5 cycles with items A,B in flight -> outputs frozen, stall_cnt=5; after release A then B exit, no loss or duplicate.
- Kill under stall: DEPTH=3, stall=1, kill=3'b010 -> stage 1 becomes bubble; on release output sequence is item0, bubble, item2; vld_count drops 3→2.
- Flush vs stall: stall=1 and flush=1 same cycle with 3 valid items -> next cycle vld_count=0, out_ctrl=CTRL_SAFE, stall_cnt=0; stall_cnt saturation checked by 70000-cycle stall -> 16'hFFFF.
